// File: rtl/ysyx_22051013_lsu_pkg.sv
// Shared definitions for the load/store unit: ls_op field positions,
// access-size encodings, FSM states and lane-offset helpers.
// Optional feature macro: YSYX_22051013_LSU_MISALIGN_TRAP_EN.
package ysyx_22051013_lsu_pkg;

    // ls_op bit positions
    localparam int OP_MEM   = 4;  // instruction touches memory
    localparam int OP_STORE = 3;  // 1 = store, 0 = load
    localparam int OP_UNS   = 2;  // zero-extend the loaded value
    localparam int OP_SZ_HI = 1;  // access size, upper bit
    localparam int OP_SZ_LO = 0;  // access size, lower bit

    // access size encodings held in ls_op[1:0]
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Byte offset forced down to the natural alignment of the access size.
    function automatic logic [2:0] lane_off(input logic [1:0] size, input logic [2:0] off);
        logic [2:0] r;
        case (size)
            SZ_B:    r = off;
            SZ_H:    r = {off[2:1], 1'b0};
            SZ_W:    r = {off[2], 2'b00};
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // An access is misaligned when alignment would move its byte offset.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        return lane_off(size, off) != off;
    endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_align.sv
// Lane steering for the LSU: store byte strobes and shifted write data,
// plus extraction and sign/zero extension of load data from a doubleword.
// Offsets are always reduced to size alignment before use.
module ysyx_22051013_lsu_align
    import ysyx_22051013_lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [2:0]        off_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [DATA_W-1:0] load_o
);

    logic [2:0]        lane;
    logic [5:0]        bit_sh;
    logic [STRB_W-1:0] base_strb;
    logic [DATA_W-1:0] rsh;

    assign lane   = lane_off(size_i, off_i);
    assign bit_sh = {lane, 3'b000};

    // Strobe pattern for an access of the given size starting at lane 0.
    always_comb begin
        base_strb = '0;
        case (size_i)
            SZ_B:    base_strb = STRB_W'(8'h01);
            SZ_H:    base_strb = STRB_W'(8'h03);
            SZ_W:    base_strb = STRB_W'(8'h0F);
            default: base_strb = STRB_W'(8'hFF);
        endcase
    end

    assign wstrb_o = base_strb << lane;
    assign wdata_o = store_data_i << bit_sh;
    assign rsh     = rdata_i >> bit_sh;

    // Truncate the shifted read data to the access size, then extend.
    always_comb begin
        load_o = '0;
        case (size_i)
            SZ_B:    load_o = unsigned_i ? {56'b0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
            SZ_H:    load_o = unsigned_i ? {48'b0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
            SZ_W:    load_o = unsigned_i ? {32'b0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
            default: load_o = rsh;
        endcase
    end

endmodule

// File: rtl/ysyx_22051013_lsu.sv
// Load/store stage after the EXU. One memory transaction per instruction
// over a valid/ready request bus with a valid-only response, then a
// valid/ready hand-off to the WBU. Non-memory ops bypass the bus.
// Optional feature macro: YSYX_22051013_LSU_MISALIGN_TRAP_EN
// (misaligned memory ops trap instead of being lane-masked).
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; the valid side holds its payload stable until then and
// never waits on ready before raising valid. mem_rsp_valid has no ready
// and is only honoured while waiting for a response.
module ysyx_22051013_lsu
    import ysyx_22051013_lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        ls_op,
    input  logic [DATA_W-1:0] exu_res,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [1:0]        dbg_state_o
);

    lsu_state_e        state_q;
    logic [OP_STORE:0] op_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] align_wdata;
    logic [STRB_W-1:0] align_wstrb;
    logic [DATA_W-1:0] align_load;
    logic              req_act;
`ifdef YSYX_22051013_LSU_MISALIGN_TRAP_EN
    logic              err_q;
`endif

    ysyx_22051013_lsu_align #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_align (
        .size_i       (op_q[OP_SZ_HI:OP_SZ_LO]),
        .unsigned_i   (op_q[OP_UNS]),
        .off_i        (addr_q[2:0]),
        .store_data_i (sdata_q),
        .rdata_i      (mem_rsp_rdata),
        .wdata_o      (align_wdata),
        .wstrb_o      (align_wstrb),
        .load_o       (align_load)
    );

    // Main FSM: accept, issue request, wait for response, present result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            out_data_q <= '0;
`ifdef YSYX_22051013_LSU_MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q    <= ls_op[OP_STORE:0];
                        addr_q  <= exu_res;
                        sdata_q <= store_data;
`ifdef YSYX_22051013_LSU_MISALIGN_TRAP_EN
                        err_q   <= 1'b0;
`endif
                        if (!ls_op[OP_MEM]) begin
                            out_data_q <= exu_res;
                            state_q    <= ST_DONE;
                        end
`ifdef YSYX_22051013_LSU_MISALIGN_TRAP_EN
                        else if (is_misaligned(ls_op[OP_SZ_HI:OP_SZ_LO], exu_res[2:0])) begin
                            // faulting address goes out as the trap value
                            out_data_q <= exu_res;
                            err_q      <= 1'b1;
                            state_q    <= ST_DONE;
                        end
`endif
                        else begin
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        out_data_q <= op_q[OP_STORE] ? '0 : align_load;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; reset forces every one to 0.
    assign req_act       = !rst && (state_q == ST_REQ);
    assign in_ready      = !rst && (state_q == ST_IDLE);
    assign mem_req_valid = req_act;
    assign mem_req_we    = req_act && op_q[OP_STORE];
    assign mem_req_addr  = req_act ? {addr_q[DATA_W-1:3], 3'b000} : '0;
    assign mem_req_wdata = (req_act && op_q[OP_STORE]) ? align_wdata : '0;
    assign mem_req_wstrb = (req_act && op_q[OP_STORE]) ? align_wstrb : '0;
    assign out_valid     = !rst && (state_q == ST_DONE);
    assign out_data      = out_valid ? out_data_q : '0;
    assign dbg_state_o   = rst ? 2'b00 : state_q;
`ifdef YSYX_22051013_LSU_MISALIGN_TRAP_EN
    assign out_err       = out_valid && err_q;
`else
    assign out_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22051013_lsu.sv
// Directed bench for ysyx_22051013_lsu: bypass, loads/stores of every
// size, bus and write-back stalls, reset mid-request, misaligned access.
module tb_ysyx_22051013_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ls_op;
  logic [63:0] exu_res;
  logic [63:0] store_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_err;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  int req_cnt;

  ysyx_22051013_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ls_op         (ls_op),
    .exu_res       (exu_res),
    .store_data    (store_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_err       (out_err),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count accepted bus requests
  always @(posedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) req_cnt <= req_cnt + 1;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
    end
  endtask

  // Non-memory op: result one cycle after accept, optional WBU stall.
  task automatic bypass_op(input string tag, input logic [63:0] val, input int out_stall);
    int base;
    base = req_cnt;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; ls_op = 5'h00; exu_res = val; store_data = 64'h5555;
    @(negedge clk);
    in_valid = 1'b0; exu_res = '1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".out_data"}, out_data, val);
    check({tag, ".no_req"}, 64'(mem_req_valid), 64'd0);
    for (int i = 0; i < out_stall; i++) begin
      @(negedge clk);
      check({tag, ".hold_data"}, out_data, val);
      check({tag, ".no_accept"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".released"}, 64'(out_valid), 64'd0);
    check({tag, ".req_cnt"}, 64'(req_cnt), 64'(base));
  endtask

  // Memory op acting as a slave with programmable stalls.
  task automatic mem_op(input string tag, input logic [4:0] op, input logic [63:0] addr,
                        input logic [63:0] sd, input logic [63:0] rdata,
                        input int req_stall, input int rsp_delay, input int out_stall,
                        input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                        input logic [7:0] exp_wstrb, input logic [63:0] exp_out);
    int base;
    base = req_cnt;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; ls_op = op; exu_res = addr; store_data = sd;
    @(negedge clk);
    in_valid = 1'b0; ls_op = 5'h1F; exu_res = '1; store_data = '1;
    check({tag, ".req_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, ".req_we"}, 64'(mem_req_we), 64'(op[3]));
    check({tag, ".req_addr"}, mem_req_addr, exp_addr);
    check({tag, ".req_wdata"}, mem_req_wdata, exp_wdata);
    check({tag, ".req_wstrb"}, 64'(mem_req_wstrb), 64'(exp_wstrb));
    for (int i = 0; i < req_stall; i++) begin
      mem_rsp_valid = 1'b1;  // must be ignored while requesting
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check({tag, ".stall_valid"}, 64'(mem_req_valid), 64'd1);
      check({tag, ".stall_addr"}, mem_req_addr, exp_addr);
      check({tag, ".stall_wdata"}, mem_req_wdata, exp_wdata);
      check({tag, ".stall_wstrb"}, 64'(mem_req_wstrb), 64'(exp_wstrb));
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check({tag, ".req_dropped"}, 64'(mem_req_valid), 64'd0);
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clk);
      check({tag, ".wait_out"}, 64'(out_valid), 64'd0);
      check({tag, ".wait_req"}, 64'(mem_req_valid), 64'd0);
    end
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".out_data"}, out_data, exp_out);
    check({tag, ".out_err"}, 64'(out_err), 64'd0);
    check({tag, ".done_in_ready"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < out_stall; i++) begin
      @(negedge clk);
      check({tag, ".hold_data"}, out_data, exp_out);
      check({tag, ".hold_noreq"}, 64'(mem_req_valid), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".released"}, 64'(out_valid), 64'd0);
    check({tag, ".one_req"}, 64'(req_cnt), 64'(base + 1));
  endtask

  initial begin
    total = 0; bad = 0; req_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; ls_op = '0; exu_res = '0; store_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.req_valid", 64'(mem_req_valid), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_data", out_data, 64'd0);
    check("rst.out_err", 64'(out_err), 64'd0);
    rst = 1'b0;

    bypass_op("bypass", 64'h1234, 0);
    bypass_op("bypass_bp", 64'hFEED_0000_CAFE_0001, 2);

    // LB / LBU, byte 3 of the doubleword is 0x80
    mem_op("lb", 5'h10, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0,
           64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
    mem_op("lbu", 5'h14, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0,
           64'h1000, 64'h0, 8'h00, 64'h80);
    // LH / LHU, halfword 1
    mem_op("lh", 5'h11, 64'h2002, 64'h0, 64'h0000_0000_F00D_0000, 0, 0, 0,
           64'h2000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_F00D);
    mem_op("lhu", 5'h15, 64'h2002, 64'h0, 64'h0000_0000_F00D_0000, 0, 0, 0,
           64'h2000, 64'h0, 8'h00, 64'hF00D);
    // LWU upper word, LD
    mem_op("lwu", 5'h16, 64'h4004, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 0, 0,
           64'h4000, 64'h0, 8'h00, 64'h8123_4567);
    mem_op("ld", 5'h13, 64'h4008, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 0, 0,
           64'h4008, 64'h0, 8'h00, 64'h8123_4567_89AB_CDEF);
    // SH lane 6, SB lane 5, SD
    mem_op("sh", 5'h19, 64'h2006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0,
           64'h2000, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0);
    mem_op("sb", 5'h18, 64'h1005, 64'h5A, 64'h1111, 0, 1, 0,
           64'h1000, 64'h0000_5A00_0000_0000, 8'h20, 64'h0);
    mem_op("sd", 5'h1B, 64'h7010, 64'h0102_0304_0506_0708, 64'h2222, 1, 0, 1,
           64'h7010, 64'h0102_0304_0506_0708, 8'hFF, 64'h0);
    // SW with all stalls
    mem_op("sw_stall", 5'h1A, 64'h5004, 64'hCAFE_BABE, 64'h3333, 3, 2, 2,
           64'h5000, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'h0);
    mem_op("lw_stall", 5'h12, 64'h5004, 64'h0, 64'h7654_3210_0000_0000, 3, 2, 2,
           64'h5000, 64'h0, 8'h00, 64'h7654_3210);

    // reset while a request is outstanding
    @(negedge clk);
    in_valid = 1'b1; ls_op = 5'h13; exu_res = 64'h6000;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstreq.req_valid", 64'(mem_req_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstreq.dropped", 64'(mem_req_valid), 64'd0);
    check("rstreq.in_ready_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstreq.in_ready", 64'(in_ready), 64'd1);
    check("rstreq.no_req", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h9999;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rstreq.late_rsp", 64'(out_valid), 64'd0);
    check("rstreq.still_idle", 64'(in_ready), 64'd1);

    // misaligned LW at 0x3002
`ifdef YSYX_22051013_LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    in_valid = 1'b1; ls_op = 5'h12; exu_res = 64'h3002;
    @(negedge clk);
    in_valid = 1'b0; exu_res = '1;
    check("mis.out_valid", 64'(out_valid), 64'd1);
    check("mis.out_err", 64'(out_err), 64'd1);
    check("mis.out_data", out_data, 64'h3002);
    check("mis.no_req", 64'(mem_req_valid), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("mis.released", 64'(out_valid), 64'd0);
`else
    mem_op("mis", 5'h12, 64'h3002, 64'h0, 64'h1122_3344_8877_6655, 0, 0, 0,
           64'h3000, 64'h0, 8'h00, 64'hFFFF_FFFF_8877_6655);
    mem_op("mis_sh", 5'h19, 64'h3003, 64'hBEEF, 64'h0, 0, 0, 0,
           64'h3000, 64'h0000_0000_BEEF_0000, 8'h0C, 64'h0);
`endif

    bypass_op("bypass_end", 64'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
